// File: rtl/wb_timer_pkg.sv
// Shared register map, CTRL field positions and channel mode encoding
// for the multi-channel Wishbone timer.
package wb_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE    = 1;
  localparam int unsigned CTRL_IE      = 2;
  localparam int unsigned CTRL_PRE_LSB = 8;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, down-counter, pending flag and one-shot
// auto-disable, driven by write strobes already decoded by the bus logic.
module timer_channel
  import wb_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_ctrl,
  input  logic             wr_load,
  input  logic             clr_pend,
  input  logic             en_wdata,
  input  mode_e            mode_wdata,
  input  logic             ie_wdata,
  input  logic [PRE_W-1:0] pre_wdata,
  input  logic [CNT_W-1:0] load_wdata,
  output logic             en,
  output mode_e            mode,
  output logic             ie,
  output logic [PRE_W-1:0] prescale,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] count,
  output logic             pending,
  output logic             irq
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic             expire;

  assign tick   = en & (pre_cnt == prescale);
  // A LOAD write on a tick edge suppresses both the decrement and the expiry.
  assign expire = tick & (count == '0) & ~wr_load;
  assign irq    = pending & ie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      count   <= '0;
      load    <= '0;
    end else if (wr_load) begin
      load    <= load_wdata;
      count   <= load_wdata;
      pre_cnt <= '0;
    end else if (!en && wr_ctrl && en_wdata) begin
      pre_cnt <= '0;
    end else if (en) begin
      if (tick) begin
        pre_cnt <= '0;
        if (count != '0)
          count <= count - CNT_W'(1);
        else if (mode == MODE_PERIODIC)
          count <= load;
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      mode     <= MODE_ONESHOT;
      ie       <= 1'b0;
      prescale <= '0;
    end else if (wr_ctrl) begin
      en       <= en_wdata;
      mode     <= mode_wdata;
      ie       <= ie_wdata;
      prescale <= pre_wdata;
    end else if (expire && mode == MODE_ONESHOT) begin
      en <= 1'b0;
    end
  end

  // Expiry has priority over a same-edge write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= 1'b0;
    else if (expire)
      pending <= 1'b1;
    else if (clr_pend)
      pending <= 1'b0;
  end

endmodule

// File: rtl/wb_timer_multi.sv
// Multi-channel Wishbone timer: bus decode, ACK/RTY generation, read mux
// and NUM_CH timer_channel instances with per-channel interrupts.
module wb_timer_multi
  import wb_timer_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PRE_W  = 8,
  parameter int unsigned ADR_W  = 30,
  parameter int unsigned DAT_W  = 32
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic [ADR_W-1:0]  ADR_I,
  input  logic [DAT_W-1:0]  DAT_I,
  output logic [DAT_W-1:0]  DAT_O,
  input  logic              CYC_I,
  input  logic              STB_I,
  input  logic              WE_I,
  output logic              ACK_O,
  output logic              RTY_O,
  output logic [NUM_CH-1:0] irq_vec_o,
  output logic              interrupt_o
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [1:0]       reg_sel;
  logic [CH_W-1:0]  ch;
  logic             req;
  logic             mapped;
  logic             wr_acc;
  logic [DAT_W-1:0] rdata;

  logic [NUM_CH-1:0] wr_ctrl, wr_load, clr_pend;
  logic [NUM_CH-1:0] ch_en, ch_ie, ch_pend;
  mode_e             ch_mode  [NUM_CH];
  logic [PRE_W-1:0]  ch_pre   [NUM_CH];
  logic [CNT_W-1:0]  ch_load  [NUM_CH];
  logic [CNT_W-1:0]  ch_count [NUM_CH];

  assign reg_sel = ADR_I[1:0];
  assign ch      = ADR_I[CH_W+1:2];
  // A response in flight blocks a new request, giving one access per 2 cycles.
  assign req     = CYC_I & STB_I & ~ACK_O & ~RTY_O;
  assign mapped  = (ADR_I[ADR_W-1:CH_W+2] == '0) && (32'(ch) < NUM_CH);
  assign wr_acc  = req & mapped & WE_I;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_ctrl[i]  = wr_acc && (ch == CH_W'(i)) && (reg_sel == REG_CTRL);
    assign wr_load[i]  = wr_acc && (ch == CH_W'(i)) && (reg_sel == REG_LOAD);
    assign clr_pend[i] = wr_acc && (ch == CH_W'(i)) && (reg_sel == REG_STATUS) && DAT_I[0];

    timer_channel #(
      .CNT_W(CNT_W),
      .PRE_W(PRE_W)
    ) u_ch (
      .clk       (CLK_I),
      .rst_n     (RST_I),
      .wr_ctrl   (wr_ctrl[i]),
      .wr_load   (wr_load[i]),
      .clr_pend  (clr_pend[i]),
      .en_wdata  (DAT_I[CTRL_EN]),
      .mode_wdata(mode_e'(DAT_I[CTRL_MODE])),
      .ie_wdata  (DAT_I[CTRL_IE]),
      .pre_wdata (DAT_I[CTRL_PRE_LSB +: PRE_W]),
      .load_wdata(DAT_I[CNT_W-1:0]),
      .en        (ch_en[i]),
      .mode      (ch_mode[i]),
      .ie        (ch_ie[i]),
      .prescale  (ch_pre[i]),
      .load      (ch_load[i]),
      .count     (ch_count[i]),
      .pending   (ch_pend[i]),
      .irq       (irq_vec_o[i])
    );
  end

  assign interrupt_o = |irq_vec_o;

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) begin
        case (reg_sel)
          REG_CTRL: begin
            rdata[CTRL_EN]                 = ch_en[i];
            rdata[CTRL_MODE]               = ch_mode[i];
            rdata[CTRL_IE]                 = ch_ie[i];
            rdata[CTRL_PRE_LSB +: PRE_W]   = ch_pre[i];
          end
          REG_LOAD:   rdata[CNT_W-1:0] = ch_load[i];
          REG_COUNT:  rdata[CNT_W-1:0] = ch_count[i];
          REG_STATUS: rdata[0]         = ch_pend[i];
          default:    rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ACK_O <= 1'b0;
      RTY_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      ACK_O <= req & mapped;
      RTY_O <= req & ~mapped;
      DAT_O <= (req & mapped & ~WE_I) ? rdata : '0;
    end
  end

endmodule
